// File: rtl/st5_writeback_queue.sv
// Stage-5 writeback: 2-entry in-order queue feeding the dual register-file write ports,
// with a pending-destination mask for the hazard unit and a retirement counter.
module st5_writeback_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rd,
    input  logic [3:0]  in_rd2,
    input  logic [15:0] in_alu_result,
    input  logic [15:0] in_mem_data,
    input  logic [15:0] in_aux_result,
    input  logic        in_mem_to_reg,
    input  logic [1:0]  in_reg_write,
    input  logic        in_write_r15,
    input  logic        wb_hold,
    output logic [3:0]  WriteReg1,
    output logic [3:0]  WriteReg2,
    output logic [15:0] WriteDataReg1,
    output logic [15:0] WriteDataReg2,
    output logic [1:0]  regWrite,
    output logic        WriteR15,
    output logic [15:0] pending_mask,
    output logic [15:0] retire_count
);

    typedef struct packed {
        logic [3:0]  rd;
        logic [3:0]  rd2;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [1:0]  rw;
        logic        r15;
    } entry_t;

    entry_t     slot0;
    entry_t     slot1;
    entry_t     new_entry;
    logic [1:0] count;
    logic       do_push;
    logic       do_pop;

    function automatic logic [15:0] dest_bits(input logic [1:0] rw, input logic [3:0] rd,
                                              input logic [3:0] rd2, input logic r15);
        logic [15:0] m;
        m = '0;
        if (rw == 2'b01 || rw == 2'b10) m[rd] = 1'b1;
        if (rw == 2'b10) m[r15 ? 4'd15 : rd2] = 1'b1;
        return m;
    endfunction

    // Ready looks only at occupancy, so a full queue refuses even while popping.
    assign in_ready = (count != 2'd2);
    assign do_push  = in_valid && in_ready;
    assign do_pop   = !wb_hold && (count != 2'd0);

    always_comb begin
        new_entry.rd  = in_rd;
        new_entry.rd2 = in_rd2;
        new_entry.d1  = in_mem_to_reg ? in_mem_data : in_alu_result;
        new_entry.d2  = in_aux_result;
        new_entry.rw  = (in_reg_write == 2'b11) ? 2'b00 : in_reg_write;
        new_entry.r15 = in_write_r15;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count         <= 2'd0;
            slot0         <= '0;
            slot1         <= '0;
            WriteReg1     <= 4'd0;
            WriteReg2     <= 4'd0;
            WriteDataReg1 <= 16'd0;
            WriteDataReg2 <= 16'd0;
            regWrite      <= 2'b00;
            WriteR15      <= 1'b0;
            retire_count  <= 16'd0;
        end else begin
            if (do_pop) begin
                WriteReg1     <= slot0.rd;
                WriteReg2     <= slot0.rd2;
                WriteDataReg1 <= slot0.d1;
                WriteDataReg2 <= slot0.d2;
                regWrite      <= slot0.rw;
                WriteR15      <= slot0.r15;
                retire_count  <= retire_count + 16'd1;
            end else begin
                regWrite <= 2'b00;
                WriteR15 <= 1'b0;
            end

            case ({do_pop, do_push})
                2'b10: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b01: begin
                    if (count == 2'd0) slot0 <= new_entry;
                    else               slot1 <= new_entry;
                    count <= count + 2'd1;
                end
                // Push with pop only happens at occupancy 1: the new entry becomes head.
                2'b11:   slot0 <= new_entry;
                default: ;
            endcase
        end
    end

    always_comb begin
        pending_mask = dest_bits(regWrite, WriteReg1, WriteReg2, WriteR15);
        if (count != 2'd0) pending_mask = pending_mask | dest_bits(slot0.rw, slot0.rd, slot0.rd2, slot0.r15);
        if (count == 2'd2) pending_mask = pending_mask | dest_bits(slot1.rw, slot1.rd, slot1.rd2, slot1.r15);
    end

endmodule

// File: tb/tb_st5_writeback_queue.sv
// Bench for st5_writeback_queue: directed scenarios plus randomized traffic against
// a queue-based reference model.
module tb_st5_writeback_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_rd = '0, in_rd2 = '0;
    logic [15:0] in_alu_result = '0, in_mem_data = '0, in_aux_result = '0;
    logic        in_mem_to_reg = 1'b0;
    logic [1:0]  in_reg_write = '0;
    logic        in_write_r15 = 1'b0;
    logic        wb_hold = 1'b0;
    logic [3:0]  WriteReg1, WriteReg2;
    logic [15:0] WriteDataReg1, WriteDataReg2;
    logic [1:0]  regWrite;
    logic        WriteR15;
    logic [15:0] pending_mask;
    logic [15:0] retire_count;

    st5_writeback_queue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_rd2(in_rd2), .in_alu_result(in_alu_result),
        .in_mem_data(in_mem_data), .in_aux_result(in_aux_result),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_write_r15(in_write_r15), .wb_hold(wb_hold),
        .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
        .WriteDataReg1(WriteDataReg1), .WriteDataReg2(WriteDataReg2),
        .regWrite(regWrite), .WriteR15(WriteR15),
        .pending_mask(pending_mask), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rd;
        logic [3:0]  rd2;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [1:0]  rw;
        logic        r15;
    } ent_t;

    ent_t        mq[$];
    logic [3:0]  m_wr1, m_wr2;
    logic [15:0] m_wd1, m_wd2;
    logic [1:0]  m_rw;
    logic        m_r15;
    logic [15:0] m_cnt;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic logic [15:0] targets(input logic [1:0] rw, input logic [3:0] a,
                                            input logic [3:0] b, input logic r15);
        logic [15:0] m;
        m = 16'd0;
        if (rw == 2'd1 || rw == 2'd2) m = m | (16'd1 << a);
        if (rw == 2'd2) m = m | (16'd1 << (r15 ? 4'd15 : b));
        return m;
    endfunction

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = targets(m_rw, m_wr1, m_wr2, m_r15);
        foreach (mq[i]) m = m | targets(mq[i].rw, mq[i].rd, mq[i].rd2, mq[i].r15);
        return m;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_wr1 = 0; m_wr2 = 0; m_wd1 = 0; m_wd2 = 0; m_rw = 0; m_r15 = 0; m_cnt = 0;
    endtask

    // Advance one clock edge, applying the queue rules to the model with the current inputs.
    task automatic tick();
        bit   acc;
        ent_t e;
        acc = in_valid && (mq.size() < 2);
        if (!wb_hold && mq.size() > 0) begin
            e = mq.pop_front();
            m_wr1 = e.rd; m_wr2 = e.rd2; m_wd1 = e.d1; m_wd2 = e.d2;
            m_rw = e.rw; m_r15 = e.r15; m_cnt = m_cnt + 16'd1;
        end else begin
            m_rw = 2'd0; m_r15 = 1'b0;
        end
        if (acc) begin
            e.rd = in_rd; e.rd2 = in_rd2;
            e.d1 = in_mem_to_reg ? in_mem_data : in_alu_result;
            e.d2 = in_aux_result;
            e.rw = (in_reg_write == 2'd3) ? 2'd0 : in_reg_write;
            e.r15 = in_write_r15;
            mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] rd, input logic [3:0] rd2,
                         input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] aux,
                         input logic m2r, input logic [1:0] rw, input logic r15);
        in_valid = v; in_rd = rd; in_rd2 = rd2; in_alu_result = alu; in_mem_data = mem;
        in_aux_result = aux; in_mem_to_reg = m2r; in_reg_write = rw; in_write_r15 = r15;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        n_checks++; if (regWrite !== 2'b00 || WriteR15 !== 1'b0) begin n_errors++; $display("FAIL reset_we got %b/%b want 00/0", regWrite, WriteR15); end
        n_checks++; if ({WriteReg1, WriteReg2, WriteDataReg1, WriteDataReg2} !== 40'd0) begin n_errors++; $display("FAIL reset_addr_data got %h want 0", {WriteReg1, WriteReg2, WriteDataReg1, WriteDataReg2}); end
        n_checks++; if (pending_mask !== 16'd0 || retire_count !== 16'd0) begin n_errors++; $display("FAIL reset_mask_cnt got %h/%h want 0/0", pending_mask, retire_count); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        drive(1, 4'd3, 4'd9, 16'h1234, 16'hAAAA, 16'h5555, 0, 2'b01, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (regWrite !== 2'b00) begin n_errors++; $display("FAIL single_latency got %b want 00", regWrite); end
        tick();
        n_checks++; if (WriteReg1 !== 4'd3 || WriteDataReg1 !== 16'h1234 || regWrite !== 2'b01) begin n_errors++; $display("FAIL single_out got %h/%h/%b want 3/1234/01", WriteReg1, WriteDataReg1, regWrite); end
        n_checks++; if (retire_count !== 16'd1) begin n_errors++; $display("FAIL single_cnt got %0d want 1", retire_count); end
        tick();
        n_checks++; if (regWrite !== 2'b00 || WriteDataReg1 !== 16'h1234) begin n_errors++; $display("FAIL single_after got %b/%h want 00/1234", regWrite, WriteDataReg1); end
    endtask

    task automatic test_dual_r15();
        drive(1, 4'd2, 4'd6, 16'h1111, 16'hBEEF, 16'h0007, 1, 2'b10, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (pending_mask !== 16'h8004) begin n_errors++; $display("FAIL dual_mask_queued got %h want 8004", pending_mask); end
        tick();
        n_checks++; if (WriteDataReg1 !== 16'hBEEF || WriteDataReg2 !== 16'h0007 || WriteR15 !== 1'b1 || regWrite !== 2'b10) begin n_errors++; $display("FAIL dual_out got %h/%h/%b/%b want BEEF/0007/1/10", WriteDataReg1, WriteDataReg2, WriteR15, regWrite); end
        n_checks++; if (pending_mask !== 16'h8004) begin n_errors++; $display("FAIL dual_mask_out got %h want 8004", pending_mask); end
        tick();
        n_checks++; if (pending_mask !== 16'h0000) begin n_errors++; $display("FAIL dual_mask_clear got %h want 0", pending_mask); end
    endtask

    task automatic test_back_to_back();
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1, 4'(i + 1), 4'(i + 8), 16'h0100 + 16'(i), 16'h0, 16'hA000 + 16'(i), 0, 2'b01, 0);
            n_checks++; if (in_ready !== (i < 2)) begin n_errors++; $display("FAIL burst_ready_%0d got %b want %b", i, in_ready, i < 2); end
            tick();
            n_checks++; if (regWrite !== 2'b00) begin n_errors++; $display("FAIL burst_hold_we_%0d got %b want 00", i, regWrite); end
        end
        wb_hold = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) in_valid = 1'b0;
            tick();
            n_checks++; if (regWrite !== 2'b01 || WriteReg1 !== 4'(i + 1) || WriteDataReg1 !== 16'h0100 + 16'(i)) begin n_errors++; $display("FAIL burst_order_%0d got %h/%h/%b want %h/%h/01", i, WriteReg1, WriteDataReg1, regWrite, i + 1, 16'h0100 + 16'(i)); end
            n_checks++; if (WriteDataReg1 !== m_wd1 || retire_count !== m_cnt) begin n_errors++; $display("FAIL burst_model_%0d got %h/%h want %h/%h", i, WriteDataReg1, retire_count, m_wd1, m_cnt); end
        end
        tick();
        n_checks++; if (regWrite !== 2'b00 || in_ready !== 1'b1) begin n_errors++; $display("FAIL burst_drained got %b/%b want 00/1", regWrite, in_ready); end
    endtask

    task automatic test_illegal_rw();
        logic [15:0] c0;
        c0 = retire_count;
        drive(1, 4'd5, 4'd5, 16'h5A5A, 16'h0, 16'h0, 0, 2'b11, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (pending_mask[5] !== 1'b0) begin n_errors++; $display("FAIL illegal_mask_q got %h want bit5 clear", pending_mask); end
        tick();
        n_checks++; if (regWrite !== 2'b00 || retire_count !== c0 + 16'd1) begin n_errors++; $display("FAIL illegal_retire got %b/%h want 00/%h", regWrite, retire_count, c0 + 16'd1); end
        n_checks++; if (pending_mask[5] !== 1'b0) begin n_errors++; $display("FAIL illegal_mask_o got %h want bit5 clear", pending_mask); end
    endtask

    task automatic test_reset_mid_drain();
        wb_hold = 1'b1;
        drive(1, 4'd7, 4'd8, 16'h7777, 0, 16'h8888, 0, 2'b10, 0);
        tick();
        drive(1, 4'd9, 4'd10, 16'h9999, 0, 16'hAAAA, 0, 2'b01, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        wb_hold = 1'b0;
        tick();
        n_checks++; if (regWrite !== 2'b10 || pending_mask === 16'd0) begin n_errors++; $display("FAIL middrain_pre got %b/%h want 10/nonzero", regWrite, pending_mask); end
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (regWrite !== 2'b00 || pending_mask !== 16'd0 || retire_count !== 16'd0 || in_ready !== 1'b1) begin n_errors++; $display("FAIL middrain_async got %b/%h/%h/%b want 00/0/0/1", regWrite, pending_mask, retire_count, in_ready); end
        n_checks++; if ({WriteReg1, WriteReg2, WriteDataReg1, WriteDataReg2} !== 40'd0) begin n_errors++; $display("FAIL middrain_addr got %h want 0", {WriteReg1, WriteReg2, WriteDataReg1, WriteDataReg2}); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (regWrite !== 2'b00 || retire_count !== 16'd0) begin n_errors++; $display("FAIL middrain_stale_%0d got %b/%h want 00/0", i, regWrite, retire_count); end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            wb_hold = ($urandom_range(0, 9) < 3);
            n_checks++; if (in_ready !== (mq.size() < 2)) begin n_errors++; $display("FAIL rand_ready_%0d got %b want %b", i, in_ready, mq.size() < 2); end
            tick();
            n_checks++;
            if (WriteReg1 !== m_wr1 || WriteReg2 !== m_wr2 || WriteDataReg1 !== m_wd1 || WriteDataReg2 !== m_wd2
                || regWrite !== m_rw || WriteR15 !== m_r15 || retire_count !== m_cnt || pending_mask !== model_mask()) begin
                n_errors++;
                $display("FAIL rand_out_%0d got %h %h %h %h %b %b %h %h want %h %h %h %h %b %b %h %h", i,
                         WriteReg1, WriteReg2, WriteDataReg1, WriteDataReg2, regWrite, WriteR15, retire_count, pending_mask,
                         m_wr1, m_wr2, m_wd1, m_wd2, m_rw, m_r15, m_cnt, model_mask());
            end
        end
        wb_hold = 1'b0;
        in_valid = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_wrap();
        bit reached;
        reached = 0;
        wb_hold = 1'b0;
        drive(1, 4'd1, 4'd2, 16'h0001, 0, 0, 0, 2'b01, 0);
        for (int i = 0; i < 70000 && !reached; i++) begin
            if (m_cnt == 16'hFFFF) reached = 1;
            else tick();
        end
        n_checks++; if (!reached) begin n_errors++; $display("FAIL wrap_timeout got %h want FFFF", m_cnt); end
        n_checks++; if (retire_count !== 16'hFFFF) begin n_errors++; $display("FAIL wrap_preload got %h want FFFF", retire_count); end
        tick();
        n_checks++; if (retire_count !== 16'h0000) begin n_errors++; $display("FAIL wrap_rollover got %h want 0000", retire_count); end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual_r15();
        test_back_to_back();
        test_illegal_rw();
        test_reset_mid_drain();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
